// File: rtl/instr_queue_if.sv
// Fetch-to-decode instruction queue bus: fetch index, synchronous ROM port, flush and decode handshake.
// master = surrounding pipeline/ROM, slave = instr_queue.
interface instr_queue_if;
    logic [31:0] index_i;
    logic        stall_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        flush_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;

    modport master (
        output index_i, mem_data_i, flush_i, ready_i,
        input  stall_o, mem_addr_o, instr_o, pc_o, valid_o
    );

    modport slave (
        input  index_i, mem_data_i, flush_i, ready_i,
        output stall_o, mem_addr_o, instr_o, pc_o, valid_o
    );
endinterface

// File: rtl/instr_queue.sv
// Instruction queue between Fetch and Decode, fed by a one-cycle synchronous ROM.
// Optional stall counter port stall_cnt_o when INSTR_QUEUE_PERF_EN is defined.
module instr_queue #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    instr_queue_if.slave   bus
`ifdef INSTR_QUEUE_PERF_EN
    ,
    output logic [15:0]    stall_cnt_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW:0]   count_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic          pending_r;
    logic [31:0]   pc_q_r;
    logic [63:0]   store_r [DEPTH];

    logic [AW+1:0] occupancy_s;
    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic          valid_s;

    // Issue only when the slot reserved by an in-flight read is still free; a same-cycle pop is not credited.
    always_comb begin
        occupancy_s = {1'b0, count_r} + {{(AW+1){1'b0}}, pending_r};
        valid_s     = (count_r != {(AW+1){1'b0}});
        issue_s     = !rst && !bus.flush_i && (occupancy_s < {1'b0, DEPTH_C});
        push_s      = pending_r && !bus.flush_i && !rst;
        pop_s       = valid_s && bus.ready_i && !bus.flush_i && !rst;
    end

    assign bus.stall_o    = !issue_s;
    assign bus.mem_addr_o = bus.index_i;
    assign bus.valid_o    = valid_s;
    assign bus.instr_o    = valid_s ? store_r[rd_ptr_r][31:0]  : 32'h0000_0000;
    assign bus.pc_o       = valid_s ? store_r[rd_ptr_r][63:32] : 32'h0000_0000;

    // Track the outstanding ROM read and the index it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 1'b0;
            pc_q_r    <= 32'h0000_0000;
        end else if (issue_s) begin
            pending_r <= 1'b1;
            pc_q_r    <= bus.index_i;
        end else begin
            pending_r <= 1'b0;
        end
    end

    // Queue pointers and occupancy; flush behaves like reset for these.
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage is not reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            store_r[wr_ptr_r] <= {pc_q_r, bus.mem_data_i};
        end
    end

`ifdef INSTR_QUEUE_PERF_EN
    // Saturating count of stalled cycles; survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= 16'h0000;
        end else if (!issue_s && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'h0001;
        end else begin
            stall_cnt_o <= stall_cnt_o;
        end
    end
`endif
endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue with a behavioural ROM[i] = 0xA000_0000 + i.
module tb_instr_queue;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    instr_queue_if bus();

`ifdef INSTR_QUEUE_PERF_EN
    logic [15:0] stall_cnt;
`endif

    instr_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef INSTR_QUEUE_PERF_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) bus.mem_data_i <= 32'hA000_0000 + bus.mem_addr_o;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clean();
        bus.flush_i = 1'b1;
        bus.ready_i = 1'b0;
        next_cycle();
        bus.flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.ready_i = 1'b0; bus.flush_i = 1'b0; bus.index_i = 32'd0;
        @(negedge clk);
        vectors++;
        if (bus.stall_o !== 1'b1) begin
            miscompares++; $display("FAIL reset_stall got %b exp 1", bus.stall_o);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b0 || bus.pc_o !== 32'd0 || bus.instr_o !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got valid=%b pc=%h instr=%h exp 0/0/0", bus.valid_o, bus.pc_o, bus.instr_o);
        end
        vectors++;
        if (bus.stall_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_release_stall got %b exp 0", bus.stall_o);
        end
        next_cycle();
    endtask

    // Starts from an empty, idle queue: one issue per cycle, head appears two cycles after issue.
    task automatic test_stream();
        bus.ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.index_i = k;
            @(negedge clk);
            vectors++;
            if (bus.stall_o !== 1'b0 || bus.mem_addr_o !== k) begin
                miscompares++;
                $display("FAIL stream_issue k=%0d got stall=%b addr=%h exp 0/%h", k, bus.stall_o, bus.mem_addr_o, k);
            end
            vectors++;
            if (k >= 2) begin
                if (bus.valid_o !== 1'b1 || bus.pc_o !== (k - 2) || bus.instr_o !== (32'hA000_0000 + k - 2)) begin
                    miscompares++;
                    $display("FAIL stream_head k=%0d got valid=%b pc=%h instr=%h exp 1/%h/%h",
                             k, bus.valid_o, bus.pc_o, bus.instr_o, k - 2, 32'hA000_0000 + k - 2);
                end
            end else begin
                if (bus.valid_o !== 1'b0 || bus.pc_o !== 32'd0 || bus.instr_o !== 32'd0) begin
                    miscompares++;
                    $display("FAIL stream_empty k=%0d got valid=%b pc=%h instr=%h exp 0/0/0",
                             k, bus.valid_o, bus.pc_o, bus.instr_o);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_fill();
        logic exp_stall;
        bus.ready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.index_i = (k < 4) ? k : 4;
            exp_stall = (k >= 4);
            @(negedge clk);
            vectors++;
            if (bus.stall_o !== exp_stall) begin
                miscompares++; $display("FAIL fill_stall k=%0d got %b exp %b", k, bus.stall_o, exp_stall);
            end
            vectors++;
            if (k >= 2) begin
                if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'd0 || bus.instr_o !== 32'hA000_0000) begin
                    miscompares++;
                    $display("FAIL fill_head k=%0d got valid=%b pc=%h instr=%h exp 1/0/a0000000",
                             k, bus.valid_o, bus.pc_o, bus.instr_o);
                end
            end else begin
                if (bus.valid_o !== 1'b0) begin
                    miscompares++; $display("FAIL fill_empty k=%0d got valid=%b exp 0", k, bus.valid_o);
                end
            end
            next_cycle();
        end
    endtask

    // Continues from a full queue holding indices 0..3.
    task automatic test_pop_one();
        bus.ready_i = 1'b1; bus.index_i = 32'd4;
        @(negedge clk);
        vectors++;
        if (bus.pc_o !== 32'd0 || bus.stall_o !== 1'b1) begin
            miscompares++; $display("FAIL pop_full got pc=%h stall=%b exp 0/1", bus.pc_o, bus.stall_o);
        end
        next_cycle();
        bus.ready_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.pc_o !== 32'd1 || bus.instr_o !== 32'hA000_0001 || bus.stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_after got pc=%h instr=%h stall=%b exp 1/a0000001/0", bus.pc_o, bus.instr_o, bus.stall_o);
        end
        next_cycle();
        bus.index_i = 32'd5;
        @(negedge clk);
        vectors++;
        if (bus.stall_o !== 1'b1 || bus.pc_o !== 32'd1) begin
            miscompares++; $display("FAIL pop_refill got stall=%b pc=%h exp 1/1", bus.stall_o, bus.pc_o);
        end
        next_cycle();
        bus.ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            vectors++;
            if (bus.valid_o !== 1'b1 || bus.pc_o !== (j + 1) || bus.instr_o !== (32'hA000_0001 + j)) begin
                miscompares++;
                $display("FAIL pop_order j=%0d got valid=%b pc=%h instr=%h exp 1/%h/%h",
                         j, bus.valid_o, bus.pc_o, bus.instr_o, j + 1, 32'hA000_0001 + j);
            end
            if (j == 0) begin
                vectors++;
                if (bus.stall_o !== 1'b1) begin
                    miscompares++; $display("FAIL pop_full_again got stall=%b exp 1", bus.stall_o);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        clean();
        bus.ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.index_i = k;
            next_cycle();
        end
        bus.index_i = 32'd4; bus.flush_i = 1'b1; bus.ready_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.stall_o !== 1'b1 || bus.valid_o !== 1'b1 || bus.pc_o !== 32'd0) begin
            miscompares++;
            $display("FAIL flush_cycle got stall=%b valid=%b pc=%h exp 1/1/0", bus.stall_o, bus.valid_o, bus.pc_o);
        end
        next_cycle();
        bus.flush_i = 1'b0; bus.ready_i = 1'b0; bus.index_i = 32'd8;
        @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b0 || bus.pc_o !== 32'd0 || bus.instr_o !== 32'd0 || bus.stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_after got valid=%b pc=%h instr=%h stall=%b exp 0/0/0/0",
                     bus.valid_o, bus.pc_o, bus.instr_o, bus.stall_o);
        end
        next_cycle();
        bus.index_i = 32'd9;
        @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b0) begin
            miscompares++; $display("FAIL flush_drop got valid=%b exp 0", bus.valid_o);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'd8 || bus.instr_o !== 32'hA000_0008) begin
            miscompares++;
            $display("FAIL flush_refill got valid=%b pc=%h instr=%h exp 1/8/a0000008", bus.valid_o, bus.pc_o, bus.instr_o);
        end
        next_cycle();
    endtask

    task automatic test_reset_full();
        clean();
        bus.ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.index_i = (k < 4) ? k : 4;
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.stall_o !== 1'b1 || bus.valid_o !== 1'b1 || bus.pc_o !== 32'd0) begin
            miscompares++;
            $display("FAIL rstfull_cycle got stall=%b valid=%b pc=%h exp 1/1/0", bus.stall_o, bus.valid_o, bus.pc_o);
        end
        next_cycle();
        rst = 1'b0;
        test_stream();
    endtask

`ifdef INSTR_QUEUE_PERF_EN
    task automatic test_perf();
        rst = 1'b1; bus.flush_i = 1'b0; bus.ready_i = 1'b0;
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            bus.index_i = (k < 4) ? k : 4;
            next_cycle();
        end
        @(negedge clk);
        vectors++;
        if (stall_cnt !== 16'd10) begin
            miscompares++; $display("FAIL perf_count got %0d exp 10", stall_cnt);
        end
        for (int k = 0; k < 65530; k++) next_cycle();
        @(negedge clk);
        vectors++;
        if (stall_cnt !== 16'hFFFF) begin
            miscompares++; $display("FAIL perf_saturate got %h exp ffff", stall_cnt);
        end
        clean();
        @(negedge clk);
        vectors++;
        if (stall_cnt !== 16'hFFFF) begin
            miscompares++; $display("FAIL perf_flush got %h exp ffff", stall_cnt);
        end
        next_cycle();
    endtask
`endif

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; bus.flush_i = 1'b0; bus.ready_i = 1'b0; bus.index_i = 32'd0;
        next_cycle();
        test_reset();
        clean();
        test_stream();
        clean();
        test_fill();
        test_pop_one();
        test_flush();
        test_reset_full();
`ifdef INSTR_QUEUE_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
